// File: rtl/dac_arb_pkg.sv
// Shared definitions for the SPI converter arbiters.
// Contents:
//   ARB_STATE_WID - width of the arbiter state encoding
//   arb_state_e   - IDLE / XFER / RELEASE / GAP
//   ptr_wid()     - width of a round-robin pointer or port index for n ports
package dac_arb_pkg;

  localparam int ARB_STATE_WID = 2;

  typedef enum logic [ARB_STATE_WID-1:0] {
    ST_IDLE    = 2'd0,
    ST_XFER    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_GAP     = 2'd3
  } arb_state_e;

  function automatic int ptr_wid(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker with lock override.
// Ports:
//   req    [PORTS]   request vector
//   ptr    [PTR_WID] highest-priority port index for this pick
//   locked           restrict the pick to the owner
//   owner  [PORTS]   one-hot lock owner (used only when locked)
//   win    [PORTS]   one-hot winner, zero when nothing eligible
//   valid            a winner exists
module rr_pick
  import dac_arb_pkg::*;
#(
  parameter int PORTS   = 3,
  parameter int PTR_WID = ptr_wid(PORTS)
) (
  input  logic [PORTS-1:0]   req,
  input  logic [PTR_WID-1:0] ptr,
  input  logic               locked,
  input  logic [PORTS-1:0]   owner,
  output logic [PORTS-1:0]   win,
  output logic               valid
);

  logic [PTR_WID-1:0] idx;

  always_comb begin
    win = '0;
    idx = '0;
    if (locked) begin
      win = req & owner;
    end else begin
      // Walk ptr, ptr+1, ... wrapping at PORTS; first requester wins.
      for (int k = 0; k < PORTS; k++) begin
        idx = PTR_WID'((int'(ptr) + k) % PORTS);
        if ((win == '0) && req[idx]) begin
          win[idx] = 1'b1;
        end
      end
    end
  end

  assign valid = |win;

endmodule

// File: rtl/dac_spi_arbiter.sv
// Shares one DAC SPI master among PORTS requesters using the arm/finished
// handshake. Round-robin arbitration, per-port lock for multi-command
// sequences, and a minimum idle gap between master transactions.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_arm      [PORTS]     per-port request
//   req_to_dac   [PORTS*W]   per-port word, port i at [i*W +: W]
//   req_lock     [PORTS]     keep grant after this port's transaction
//   req_finished [PORTS]     per-port completion
//   from_dac     [W]         last word read back (shared)
//   grant        [PORTS]     one-hot owner, zero when idle and unlocked
//   dac_arm, to_dac          to SPI master
//   dac_from, dac_finished   from SPI master
module dac_spi_arbiter
  import dac_arb_pkg::*;
#(
  parameter int PORTS            = 3,
  parameter int DAC_WID          = 24,
  parameter int WAIT_BETWEEN_CMD = 10,
  parameter int TIMER_WID        = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PORTS-1:0]           req_arm,
  input  logic [PORTS*DAC_WID-1:0]   req_to_dac,
  input  logic [PORTS-1:0]           req_lock,
  output logic [PORTS-1:0]           req_finished,
  output logic [DAC_WID-1:0]         from_dac,
  output logic [PORTS-1:0]           grant,
  output logic                       dac_arm,
  output logic [DAC_WID-1:0]         to_dac,
  input  logic [DAC_WID-1:0]         dac_from,
  input  logic                       dac_finished
);

  localparam int PTR_WID = ptr_wid(PORTS);
  localparam logic [TIMER_WID-1:0] GAP_LAST = TIMER_WID'(WAIT_BETWEEN_CMD - 1);

  arb_state_e           state_q, state_d;
  logic [PTR_WID-1:0]   ptr_q, ptr_d;
  logic                 locked_q, locked_d;
  logic [TIMER_WID-1:0] gap_cnt_q, gap_cnt_d;
  logic [PORTS-1:0]     grant_q, grant_d;
  logic                 dac_arm_q, dac_arm_d;
  logic [DAC_WID-1:0]   to_dac_q, to_dac_d;
  logic [DAC_WID-1:0]   from_dac_q, from_dac_d;
  logic [PORTS-1:0]     req_finished_q, req_finished_d;

  logic [PORTS-1:0]     pick_win;
  logic                 pick_valid;
  logic                 arm_g, lock_g, lock_drop, gap_done;
  logic [PTR_WID-1:0]   ptr_next;
  logic [DAC_WID-1:0]   pick_data;

  // The granted port's own arm/lock bits, selected by the one-hot grant.
  assign arm_g     = |(req_arm & grant_q);
  assign lock_g    = |(req_lock & grant_q);
  assign lock_drop = locked_q && !lock_g;
  // dac_arm is low during every GAP cycle plus the IDLE cycle that follows,
  // giving WAIT_BETWEEN_CMD+1 low cycles between transactions.
  assign gap_done  = (gap_cnt_q >= GAP_LAST) && !dac_finished;

  rr_pick #(
    .PORTS   (PORTS),
    .PTR_WID (PTR_WID)
  ) u_pick (
    .req    (req_arm),
    .ptr    (ptr_q),
    .locked (locked_q),
    .owner  (grant_q),
    .win    (pick_win),
    .valid  (pick_valid)
  );

  always_comb begin
    ptr_next  = '0;
    pick_data = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_q[i]) ptr_next = (i == PORTS - 1) ? '0 : PTR_WID'(i + 1);
      if (pick_win[i]) pick_data = req_to_dac[i*DAC_WID +: DAC_WID];
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (!lock_drop && pick_valid) state_d = ST_XFER;
      ST_XFER:    if (dac_finished) state_d = arm_g ? ST_RELEASE : ST_GAP;
      ST_RELEASE: if (!arm_g) state_d = ST_GAP;
      ST_GAP:     if (gap_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    ptr_d          = ptr_q;
    locked_d       = locked_q;
    grant_d        = grant_q;
    dac_arm_d      = dac_arm_q;
    to_dac_d       = to_dac_q;
    from_dac_d     = from_dac_q;
    req_finished_d = req_finished_q;
    gap_cnt_d      = '0;
    case (state_q)
      ST_IDLE: begin
        if (lock_drop) begin
          // Lock released: clear this cycle, arbitrate from the next one.
          locked_d = 1'b0;
          grant_d  = '0;
        end else if (pick_valid) begin
          grant_d   = pick_win;
          dac_arm_d = 1'b1;
          to_dac_d  = pick_data;
        end
      end
      ST_XFER: begin
        if (dac_finished) begin
          from_dac_d = dac_from;
          if (arm_g) req_finished_d = grant_q;
          else       dac_arm_d      = 1'b0;  // abandoned by the requester
        end
      end
      ST_RELEASE: begin
        if (!arm_g) begin
          req_finished_d = '0;
          dac_arm_d      = 1'b0;
        end
      end
      ST_GAP: begin
        gap_cnt_d = (gap_cnt_q < GAP_LAST) ? gap_cnt_q + 1'b1 : gap_cnt_q;
        if (gap_done) begin
          locked_d = lock_g;
          ptr_d    = ptr_next;
          grant_d  = lock_g ? grant_q : '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q          <= '0;
      locked_q       <= 1'b0;
      gap_cnt_q      <= '0;
      grant_q        <= '0;
      dac_arm_q      <= 1'b0;
      to_dac_q       <= '0;
      from_dac_q     <= '0;
      req_finished_q <= '0;
    end else begin
      ptr_q          <= ptr_d;
      locked_q       <= locked_d;
      gap_cnt_q      <= gap_cnt_d;
      grant_q        <= grant_d;
      dac_arm_q      <= dac_arm_d;
      to_dac_q       <= to_dac_d;
      from_dac_q     <= from_dac_d;
      req_finished_q <= req_finished_d;
    end
  end

  assign grant        = grant_q;
  assign dac_arm      = dac_arm_q;
  assign to_dac       = to_dac_q;
  assign from_dac     = from_dac_q;
  assign req_finished = req_finished_q;

endmodule

// File: tb/tb_dac_spi_arbiter.sv
// Testbench for dac_spi_arbiter: directed vector table plus hand-written
// sequences for round robin, lock, abandon, reset and data isolation.
module tb_dac_spi_arbiter;

  localparam int PORTS   = 3;
  localparam int DAC_WID = 24;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [PORTS-1:0]         req_arm;
  logic [PORTS*DAC_WID-1:0] req_to_dac;
  logic [PORTS-1:0]         req_lock;
  logic [PORTS-1:0]         req_finished;
  logic [DAC_WID-1:0]       from_dac;
  logic [PORTS-1:0]         grant;
  logic                     dac_arm;
  logic [DAC_WID-1:0]       to_dac;
  logic [DAC_WID-1:0]       dac_from;
  logic                     dac_finished;

  dac_spi_arbiter #(
    .PORTS(PORTS), .DAC_WID(DAC_WID), .WAIT_BETWEEN_CMD(10), .TIMER_WID(4)
  ) dut (
    .clk(clk), .rst(rst), .req_arm(req_arm), .req_to_dac(req_to_dac),
    .req_lock(req_lock), .req_finished(req_finished), .from_dac(from_dac),
    .grant(grant), .dac_arm(dac_arm), .to_dac(to_dac), .dac_from(dac_from),
    .dac_finished(dac_finished)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // SPI master model: pulses dac_finished for one cycle spi_lat cycles
  // after dac_arm rises, then waits for dac_arm to fall.
  int                 spi_lat = 5;
  logic [DAC_WID-1:0] spi_resp = '0;
  int                 spi_cnt = 0;
  bit                 spi_done = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rst || !dac_arm) begin
      spi_cnt      = 0;
      spi_done     = 1'b0;
      dac_finished = 1'b0;
      dac_from     = '0;
    end else if (spi_done) begin
      dac_finished = 1'b0;
    end else begin
      spi_cnt++;
      if (spi_cnt == spi_lat) begin
        dac_finished = 1'b1;
        dac_from     = spi_resp;
        spi_done     = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_data(input int p, input logic [DAC_WID-1:0] d);
    req_to_dac[p*DAC_WID +: DAC_WID] = d;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_arm    = '0;
    req_lock   = '0;
    req_to_dac = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    int                 port;
    logic [DAC_WID-1:0] data;
    logic [DAC_WID-1:0] resp;
    int                 lat;
    logic [PORTS-1:0]   exp_grant;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, low, seen, bad, badf;
    bit prev_arm;

    vecs[0] = '{1, 24'h1ABCDE, 24'h012345, 5, 3'b010};
    vecs[1] = '{0, 24'hFFFFFF, 24'h000000, 1, 3'b001};
    vecs[2] = '{2, 24'h000001, 24'hABCDEF, 3, 3'b100};
    vecs[3] = '{2, 24'h800000, 24'h7FFFFF, 8, 3'b100};

    do_reset();
    chk("rst_grant", grant, 0);
    chk("rst_dac_arm", dac_arm, 0);
    chk("rst_req_finished", req_finished, 0);
    chk("rst_to_dac", to_dac, 0);
    chk("rst_from_dac", from_dac, 0);

    // Single-request transactions from the vector table
    for (int v = 0; v < 4; v++) begin
      spi_lat  = vecs[v].lat;
      spi_resp = vecs[v].resp;
      set_data(vecs[v].port, vecs[v].data);
      req_arm[vecs[v].port] = 1'b1;
      tick();
      chk("vec_grant", grant, vecs[v].exp_grant);
      chk("vec_dac_arm", dac_arm, 1);
      chk("vec_to_dac", to_dac, vecs[v].data);
      n = 0;
      while (!req_finished[vecs[v].port] && n < 40) begin
        tick();
        n++;
      end
      chk("vec_finished", req_finished, vecs[v].exp_grant);
      chk("vec_fin_latency", n, vecs[v].lat);
      chk("vec_from_dac", from_dac, vecs[v].resp);
      req_arm[vecs[v].port] = 1'b0;
      tick();
      chk("vec_arm_low", dac_arm, 0);
      chk("vec_finished_low", req_finished, 0);
      repeat (12) tick();
      chk("vec_grant_idle", grant, 0);
    end

    // Round robin: every port re-arms as soon as its finished drops
    do_reset();
    spi_lat  = 3;
    spi_resp = 24'h00C0DE;
    low      = 0;
    seen     = 0;
    prev_arm = 1'b0;
    for (int c = 0; c < 400 && seen < 6; c++) begin
      req_arm = ~req_finished;
      tick();
      if (dac_arm && !prev_arm) begin
        chk("rr_order", grant, 3'b001 << (seen % 3));
        if (seen > 0) chk("rr_gap_ge11", (low >= 11), 1);
        seen++;
        low = 0;
      end
      if (!dac_arm) low++;
      prev_arm = dac_arm;
    end
    chk("rr_count", seen, 6);

    // Lock: port 2 runs three transactions while ports 0 and 1 wait
    do_reset();
    spi_lat  = 2;
    spi_resp = 24'h0000AA;
    bad      = 0;
    req_lock = 3'b100;
    req_arm  = 3'b100;
    tick();
    chk("lock_first_grant", grant, 3'b100);
    req_arm[1:0] = 2'b11;
    for (int t = 0; t < 3; t++) begin
      n = 0;
      while (!req_finished[2] && n < 100) begin
        tick();
        if (grant != 3'b100) bad++;
        n++;
      end
      chk("lock_fin", req_finished, 3'b100);
      req_arm[2] = 1'b0;
      tick();
      if (grant != 3'b100) bad++;
      if (t < 2) begin
        req_arm[2] = 1'b1;
        n = 0;
        while (!dac_arm && n < 100) begin
          tick();
          if (grant != 3'b100) bad++;
          n++;
        end
        chk("lock_rearm", {dac_arm, grant}, 4'b1100);
      end
    end
    repeat (20) begin
      tick();
      if (grant != 3'b100 || dac_arm) bad++;
    end
    chk("lock_no_other_grant", bad, 0);
    req_lock[2] = 1'b0;
    tick();
    chk("lock_clear", grant, 0);
    tick();
    chk("lock_next_port0", grant, 3'b001);
    chk("lock_next_arm", dac_arm, 1);

    // Abandon: port 0 drops arm mid-transfer
    do_reset();
    spi_lat  = 6;
    spi_resp = 24'h5A5A5A;
    set_data(0, 24'h111111);
    req_arm = 3'b001;
    tick();
    chk("abn_grant", grant, 3'b001);
    tick();
    req_arm[0] = 1'b0;
    n    = 0;
    badf = 0;
    while (dac_arm && n < 50) begin
      if (req_finished != 0) badf++;
      tick();
      n++;
    end
    chk("abn_hold_cycles", n, 5);
    chk("abn_no_finished", badf, 0);
    chk("abn_finished_low", req_finished, 0);
    chk("abn_from_dac", from_dac, 24'h5A5A5A);
    req_arm = 3'b010;
    low = 1;
    n   = 0;
    while (!dac_arm && n < 50) begin
      tick();
      if (!dac_arm) low++;
      n++;
    end
    chk("abn_next_grant", grant, 3'b010);
    chk("abn_gap_ge11", (low >= 11), 1);

    // Reset while a transfer is in progress
    do_reset();
    spi_lat = 20;
    set_data(2, 24'h0BEEF0);
    req_arm = 3'b100;
    tick();
    chk("rst_mid_arm", dac_arm, 1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {dac_arm, grant, req_finished}, 0);
    chk("rst_mid_to_dac", to_dac, 0);
    rst     = 1'b0;
    req_arm = 3'b111;
    tick();
    chk("rst_mid_prio", grant, 3'b001);

    // Data isolation: port 1 changes its word during the transfer
    do_reset();
    spi_lat  = 6;
    spi_resp = 24'h0F0F0F;
    set_data(1, 24'h234567);
    req_arm = 3'b010;
    tick();
    chk("iso_to_dac_grant", to_dac, 24'h234567);
    set_data(1, 24'h765432);
    tick();
    tick();
    chk("iso_to_dac_held", to_dac, 24'h234567);
    n = 0;
    while (!req_finished[1] && n < 40) begin
      tick();
      n++;
    end
    chk("iso_finished", req_finished, 3'b010);
    chk("iso_to_dac_end", to_dac, 24'h234567);
    chk("iso_from_dac", from_dac, 24'h0F0F0F);
    req_arm = 3'b000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
